// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding,
// the all-off segment pattern and the hex-to-segment table {a,b,c,d,e,f,g}.
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110010;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bin_2_7.sv
// Combinational hex-to-7-segment decoder shared by all digits of the scan.
import seg_scan_ctrl_pkg::*;

module bin_2_7 (
    input  logic [3:0] i_bin,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_bin);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display.
// Optional feature: define SEG_LZB_EN to blank leading zeros (digit 0 always shown).
import seg_scan_ctrl_pkg::*;

module seg_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int PRESC     = 1000,
    parameter int BLANK_CYC = 16,
    localparam int AW       = $clog2(NDIG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [3:0]      wr_data,
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg,
    output logic            frame_tick,
    output state_t          dbg_state
);

    localparam int MAXC = (PRESC > BLANK_CYC) ? PRESC : BLANK_CYC;
    localparam int CW   = $clog2(MAXC);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_idx;
    logic [3:0]        r_dig [NDIG];
    logic [NDIG-1:0]   r_an;
    logic [6:0]        r_seg;
    logic              r_wrap;
    logic              r_tick;

    state_t            w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [AW-1:0]     w_idx_nxt;
    logic              w_wrap;
    logic              w_show;
    logic              w_addr_ok;
    logic              w_lz_blank;
    logic [6:0]        w_seg_dec;
    logic [NDIG-1:0]   w_an_nxt;
    logic [6:0]        w_seg_nxt;

    // Single shared decoder, fed by the digit currently selected by the scan index.
    bin_2_7 u_dec (
        .i_bin (r_dig[r_idx]),
        .o_seg (w_seg_dec)
    );

    assign w_addr_ok = (32'(wr_addr) < 32'(NDIG));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        if (!en) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == CW'(BLANK_CYC - 1)) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == CW'(PRESC - 1)) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        if (r_idx == AW'(NDIG - 1)) begin
                            w_idx_nxt = '0;
                            w_wrap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef SEG_LZB_EN
    logic [NDIG-1:0] w_lz;
    logic            v_zero;

    // w_lz[k]: digit k and every higher digit are zero; digit 0 is never blanked.
    always_comb begin
        w_lz   = '0;
        v_zero = 1'b0;
        for (int k = 1; k < NDIG; k++) begin
            v_zero = 1'b1;
            for (int j = k; j < NDIG; j++) begin
                v_zero = v_zero & (r_dig[j] == 4'h0);
            end
            w_lz[k] = v_zero;
        end
    end

    assign w_lz_blank = w_lz[r_idx];
`else
    assign w_lz_blank = 1'b0;
`endif

    // Gating with en makes the display go dark on the very edge en is seen low.
    assign w_show    = en && (r_state == ST_SHOW);
    assign w_an_nxt  = w_show ? (NDIG'(1) << r_idx) : '0;
    assign w_seg_nxt = (w_show && !w_lz_blank) ? w_seg_dec : SEG_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_an    <= '0;
            r_seg   <= SEG_OFF;
            r_wrap  <= 1'b0;
            r_tick  <= 1'b0;
            for (int k = 0; k < NDIG; k++) begin
                r_dig[k] <= 4'h0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_wrap  <= w_wrap;
            r_tick  <= r_wrap;
            if (wr_en && w_addr_ok) begin
                r_dig[wr_addr] <= wr_data;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_tick;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NDIG=4 and NDIG=3, PRESC=8, BLANK_CYC=2).
import seg_scan_ctrl_pkg::*;

module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;
  state_t     dbg_state;

  logic       rst3 = 1'b1;
  logic       en3 = 1'b0;
  logic       wr_en3 = 1'b0;
  logic [1:0] wr_addr3 = '0;
  logic [3:0] wr_data3 = '0;
  logic [2:0] an3;
  logic [6:0] seg3;
  logic       frame_tick3;
  state_t     dbg_state3;

  int total = 0;
  int bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(4), .PRESC(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .an(an), .seg(seg), .frame_tick(frame_tick),
    .dbg_state(dbg_state)
  );

  seg_scan_ctrl #(.NDIG(3), .PRESC(8), .BLANK_CYC(2)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .wr_en(wr_en3), .wr_addr(wr_addr3),
    .wr_data(wr_data3), .an(an3), .seg(seg3), .frame_tick(frame_tick3),
    .dbg_state(dbg_state3)
  );

  // Expected segment patterns, written out by hand.
  localparam logic [6:0] E_0 = 7'b1111110;
  localparam logic [6:0] E_1 = 7'b0110000;
  localparam logic [6:0] E_2 = 7'b1101101;
  localparam logic [6:0] E_3 = 7'b1111001;
  localparam logic [6:0] E_5 = 7'b1011011;
  localparam logic [6:0] E_7 = 7'b1110010;
  localparam logic [6:0] E_9 = 7'b1111011;
  localparam logic [6:0] E_A = 7'b1110111;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr4(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] a, input logic [3:0] d);
    wr_en3 = 1'b1; wr_addr3 = a; wr_data3 = d;
    step(1);
    wr_en3 = 1'b0;
  endtask

  // Timing model: c = edges since scan start; slot of 10 clocks = 2 dark + 8 lit.
  function automatic int exp_digit(input int c, input int ndig);
    int p;
    p = (c - 1) % (ndig * 10);
    if ((p % 10) >= 2) return p / 10;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    step(2);
    total++;
    if (an !== 4'b0000) begin bad++; $display("FAIL reset_an: got %b want 0000", an); end
    total++;
    if (seg !== 7'b0) begin bad++; $display("FAIL reset_seg: got %b want 0000000", seg); end
    total++;
    if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    total++;
    if (dbg_state !== ST_BLANK) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_scan();
    logic [6:0] segs [4];
    logic [3:0] ea;
    logic [6:0] es;
    int d;
    segs[0] = E_1; segs[1] = E_2; segs[2] = E_3; segs[3] = E_A;
    rst = 1'b0; en = 1'b0;
    wr4(2'd0, 4'h1); wr4(2'd1, 4'h2); wr4(2'd2, 4'h3); wr4(2'd3, 4'hA);
    en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      d = exp_digit(c, 4);
      ea = (d < 0) ? 4'b0000 : 4'(1 << d);
      es = (d < 0) ? 7'b0 : segs[d];
      total++;
      if (an !== ea || seg !== es) begin
        bad++;
        $display("FAIL scan c=%0d: got an=%b seg=%b want an=%b seg=%b", c, an, seg, ea, es);
      end
    end
  endtask

  task automatic test_frame_tick();
    logic et;
    for (int c = 41; c <= 160; c++) begin
      step(1);
      et = ((c % 40) == 1);
      total++;
      if (frame_tick !== et) begin
        bad++;
        $display("FAIL frame_tick c=%0d: got %b want %b", c, frame_tick, et);
      end
      total++;
      if (!$onehot0(an)) begin
        bad++;
        $display("FAIL an_onehot c=%0d: got %b want at most one bit", c, an);
      end
    end
  endtask

  task automatic test_ndig3();
    logic [6:0] segs [3];
    logic [6:0] es;
    int d;
    segs[0] = E_1; segs[1] = E_2; segs[2] = E_3;
    rst3 = 1'b1; en3 = 1'b0;
    step(1);
    rst3 = 1'b0;
    wr3(2'd0, 4'h1); wr3(2'd1, 4'h2); wr3(2'd2, 4'h3);
    wr3(2'd3, 4'hF);
    en3 = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      step(1);
      if (c == 44) begin wr_en3 = 1'b1; wr_addr3 = 2'd1; wr_data3 = 4'h7; end
      if (c == 45) wr_en3 = 1'b0;
      if (c <= 30) begin
        d = exp_digit(c, 3);
        es = (d < 0) ? 7'b0 : segs[d];
        total++;
        if (seg3 !== es) begin
          bad++;
          $display("FAIL ndig3_frame c=%0d: got seg=%b want %b", c, seg3, es);
        end
      end
      if (c == 45) begin
        total++;
        if (an3 !== 3'b010 || seg3 !== E_2) begin
          bad++;
          $display("FAIL ndig3_prewrite: got an=%b seg=%b want an=010 seg=%b", an3, seg3, E_2);
        end
      end
      if (c == 46) begin
        total++;
        if (an3 !== 3'b010 || seg3 !== E_7) begin
          bad++;
          $display("FAIL ndig3_live_write: got an=%b seg=%b want an=010 seg=%b", an3, seg3, E_7);
        end
      end
    end
  endtask

  task automatic test_en_low();
    rst = 1'b1; en = 1'b0;
    step(1);
    rst = 1'b0;
    wr4(2'd0, 4'h1); wr4(2'd1, 4'h2); wr4(2'd2, 4'h3); wr4(2'd3, 4'hA);
    en = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step(1);
      if (c == 25) begin
        total++;
        if (an !== 4'b0100) begin bad++; $display("FAIL en_pre: got an=%b want 0100", an); end
        en = 1'b0;
      end
      if (c == 30) en = 1'b1;
      if (c >= 26 && c <= 32) begin
        total++;
        if (an !== 4'b0000 || seg !== 7'b0) begin
          bad++;
          $display("FAIL en_dark c=%0d: got an=%b seg=%b want 0000/0000000", c, an, seg);
        end
      end
      if (c == 33) begin
        total++;
        if (an !== 4'b0100 || seg !== E_3) begin
          bad++;
          $display("FAIL en_resume: got an=%b seg=%b want an=0100 seg=%b", an, seg, E_3);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    step(1);
    total++;
    if (an !== 4'b0000 || seg !== 7'b0 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got an=%b seg=%b tick=%b want all zero", an, seg, frame_tick);
    end
    rst = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step(1);
      if (c == 9) begin wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9; end
      if (c == 10) wr_en = 1'b0;
      if (c == 3) begin
        total++;
        if (an !== 4'b0001 || seg !== E_0) begin
          bad++;
          $display("FAIL rst_cleared_dig: got an=%b seg=%b want an=0001 seg=%b", an, seg, E_0);
        end
      end
      if (c == 13) begin
        total++;
        if (an !== 4'b0010 || seg !== E_9) begin
          bad++;
          $display("FAIL write_at_advance: got an=%b seg=%b want an=0010 seg=%b", an, seg, E_9);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] e_hi;
`ifdef SEG_LZB_EN
    e_hi = 7'b0;
`else
    e_hi = E_0;
`endif
    rst = 1'b1; en = 1'b0;
    step(1);
    rst = 1'b0;
    wr4(2'd1, 4'h5);
    en = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step(1);
      if (c == 3) begin
        total++;
        if (an !== 4'b0001 || seg !== E_0) begin
          bad++; $display("FAIL lzb_d0: got an=%b seg=%b want an=0001 seg=%b", an, seg, E_0);
        end
      end
      if (c == 13) begin
        total++;
        if (an !== 4'b0010 || seg !== E_5) begin
          bad++; $display("FAIL lzb_d1: got an=%b seg=%b want an=0010 seg=%b", an, seg, E_5);
        end
      end
      if (c == 23) begin
        total++;
        if (an !== 4'b0100 || seg !== e_hi) begin
          bad++; $display("FAIL lzb_d2: got an=%b seg=%b want an=0100 seg=%b", an, seg, e_hi);
        end
      end
      if (c == 33) begin
        total++;
        if (an !== 4'b1000 || seg !== e_hi) begin
          bad++; $display("FAIL lzb_d3: got an=%b seg=%b want an=1000 seg=%b", an, seg, e_hi);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_tick();
    test_ndig3();
    test_en_low();
    test_rst_mid();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
